// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
//   Shared types and helpers for the multi-cycle adder controller.
//   - adder_state_e : controller FSM state (IDLE -> RUN -> DONE -> IDLE)
//   - idx_width()   : width of the chunk index counter (never below 1 bit)
// ----------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } adder_state_e;

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// ----------------------------------------------------------------------------
// full_adder / chunk_adder
//   Purely combinational CHUNK-bit ripple-carry adder slice built from
//   full_adder cells. The controller owns a single instance and feeds it one
//   chunk of the operands per cycle.
//   Ports (chunk_adder):
//     a, b  in  CHUNK  operand chunks
//     cin   in  1      carry into bit 0
//     sum   out CHUNK  chunk sum
//     cout  out 1      carry out of the top bit
// ----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[CHUNK];
endmodule

// File: rtl/multicycle_adder_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_adder_ctrl
//   WIDTH-bit add/subtract computed over NCHUNK = WIDTH/CHUNK cycles by
//   reusing one CHUNK-bit adder slice, with the carry held in a register
//   between chunks. Valid/ready handshakes on the operand and result sides;
//   one operation in flight at a time.
//   Ports:
//     clk        in   1      clock, all state updates on posedge
//     reset      in   1      synchronous, active-high
//     in_valid   in   1      a, b, sub valid
//     in_ready   out  1      operands can be accepted (IDLE only)
//     a, b       in   WIDTH  operands
//     sub        in   1      1: a - b, 0: a + b
//     out_valid  out  1      result valid (DONE only)
//     out_ready  in   1      consumer takes result
//     sum        out  WIDTH  registered result
//     cout       out  1      final carry (for sub: 1 = no borrow)
//     overflow   out  1      two's-complement signed overflow
//     busy       out  1      controller not IDLE
// ----------------------------------------------------------------------------
module multicycle_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    // Guarded so a zero CHUNK reports the error instead of dividing by zero.
    localparam int NCHUNK = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (CHUNK < 1) begin : g_bad_chunk
        $error("multicycle_adder_ctrl: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
        $error("multicycle_adder_ctrl: WIDTH must be a multiple of CHUNK");
    end

    adder_state_e     state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;      // b already inverted for subtract
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
    logic             c_chunk;

    // Select the operand chunk addressed by idx for the shared slice.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_chunk = opa_q[i*CHUNK +: CHUNK];
                b_chunk = opb_q[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_q),
        .sum  (s_chunk),
        .cout (c_chunk)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d   = a;
                    opb_d   = b ^ {WIDTH{sub}};
                    carry_d = sub;   // +1 of the two's-complement negate
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NCHUNK; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        sum_d[i*CHUNK +: CHUNK] = s_chunk;
                    end
                end
                carry_d = c_chunk;
                if (idx_q == LAST_IDX) begin
                    // Top chunk: its MSB is the result sign bit.
                    cout_d  = c_chunk;
                    ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                              (s_chunk[CHUNK-1] != opa_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_multicycle_adder_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_adder_ctrl
//   Self-checking bench for multicycle_adder_ctrl (WIDTH=16, CHUNK=4).
//   Expected results come from integer arithmetic on the operands.
// ----------------------------------------------------------------------------
module tb_multicycle_adder_ctrl;

    localparam int W = 16;
    localparam int C = 4;
    localparam int EXP_LAT = W / C;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_adder_ctrl #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    // in_ready and out_valid must never be high together.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checks++;
            if (in_ready === 1'b1 && out_valid === 1'b1) begin
                errors++;
                $display("FAIL excl: in_ready=%b out_valid=%b required not both 1",
                         in_ready, out_valid);
            end
        end
    end

    // Reference: {overflow, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        longint ux, uy, sx, sy, u, r;
        logic [W-1:0] rs;
        logic c, o;
        ux = x;
        uy = y;
        sx = $signed(x);
        sy = $signed(y);
        if (s) begin
            u = ux - uy;
            c = (ux >= uy);
            r = sx - sy;
        end else begin
            u = ux + uy;
            c = (u >= 65536);
            r = sx + sy;
        end
        rs = u[W-1:0];
        o  = (r > 32767) || (r < -32768);
        return {o, c, rs};
    endfunction

    // Drive one operation, measure latency (posedges after accept), optionally
    // hold out_ready low for `hold` cycles in DONE, then complete the handshake.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input int hold, output logic [W-1:0] rsum, output logic rc,
                          output logic ro, output int lat);
        int n;
        @(negedge clk);
        a = x; b = y; sub = s; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = k - 1;
                break;
            end
        end
        rsum = sum;
        rc   = cout;
        ro   = overflow;
        if (lat >= 0) begin
            repeat (hold) @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL rst_sum: got %h want 0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL rst_cout: got %b want 0", cout); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [W-1:0] vb [4] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
        logic         vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] rs;
        logic rc, ro;
        int lat;
        logic [W+1:0] e;
        for (int i = 0; i < 4; i++) begin
            e = model(va[i], vb[i], vs[i]);
            run_op(va[i], vb[i], vs[i], 0, rs, rc, ro, lat);
            checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL dir%0d_lat: got %0d want %0d", i, lat, EXP_LAT); end
            checks++; if (rs !== e[W-1:0]) begin errors++; $display("FAIL dir%0d_sum: got %h want %h", i, rs, e[W-1:0]); end
            checks++; if (rc !== e[W]) begin errors++; $display("FAIL dir%0d_cout: got %b want %b", i, rc, e[W]); end
            checks++; if (ro !== e[W+1]) begin errors++; $display("FAIL dir%0d_ovf: got %b want %b", i, ro, e[W+1]); end
        end
    endtask

    task automatic test_backpressure();
        logic [W+1:0] e;
        int n;
        e = model(16'h9357, 16'hA468, 1'b0);
        @(negedge clk);
        a = 16'h9357; b = 16'hA468; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 a = 16'hAAAA; b = 16'h5555; sub = 1'b1;   // in_valid stays high
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid !== 1'b1 && n < 20);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_reach_done: out_valid=%b want 1", out_valid); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (sum !== e[W-1:0]) begin errors++; $display("FAIL bp_sum%0d: got %h want %h", i, sum, e[W-1:0]); end
            checks++; if (cout !== e[W]) begin errors++; $display("FAIL bp_cout%0d: got %b want %b", i, cout, e[W]); end
            checks++; if (overflow !== e[W+1]) begin errors++; $display("FAIL bp_ovf%0d: got %b want %b", i, overflow, e[W+1]); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid%0d: got %b want 1", i, out_valid); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle_after: busy=%b want 0", busy); end
        checks++; if (sum !== e[W-1:0]) begin errors++; $display("FAIL bp_sum_kept: got %h want %h", sum, e[W-1:0]); end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] rs;
        logic rc, ro;
        int lat;
        int seen;
        logic [W+1:0] e;
        @(negedge clk);
        a = 16'hF0F0; b = 16'h0F0F; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);             // accept
        #1 in_valid = 1'b0;
        @(posedge clk);             // chunk 0
        @(posedge clk);             // chunk 1, idx now 2
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b want 0", out_valid); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL abort_sum: got %h want 0000", sum); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid === 1'b1) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_result: out_valid cycles=%0d want 0", seen); end
        out_ready = 1'b0;
        e = model(16'h1234, 16'h1111, 1'b0);
        run_op(16'h1234, 16'h1111, 1'b0, 0, rs, rc, ro, lat);
        checks++; if (rs !== e[W-1:0]) begin errors++; $display("FAIL abort_next_sum: got %h want %h", rs, e[W-1:0]); end
        checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL abort_next_lat: got %0d want %0d", lat, EXP_LAT); end
    endtask

    task automatic test_back_to_back();
        localparam int N = 5;
        logic [W-1:0] xa [N];
        logic [W-1:0] xb [N];
        logic         xs [N];
        logic [W+1:0] expq [$];
        logic [W+1:0] e;
        int acc_cyc [N];
        int nacc, nres, cyc, extra;
        logic accepted;
        for (int i = 0; i < N; i++) begin
            xa[i] = W'($urandom);
            xb[i] = W'($urandom);
            xs[i] = 1'($urandom);
        end
        @(negedge clk);
        a = xa[0]; b = xb[0]; sub = xs[0]; in_valid = 1'b1; out_ready = 1'b1;
        nacc = 0; nres = 0; cyc = 0;
        while (nres < N && cyc < 200) begin
            accepted = 1'b0;
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                acc_cyc[nacc] = cyc;
                expq.push_back(model(a, b, sub));
                nacc++;
                accepted = 1'b1;
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_dup: unexpected result %h, none outstanding", sum);
                end else begin
                    e = expq.pop_front();
                    if ({overflow, cout, sum} !== e) begin
                        errors++;
                        $display("FAIL b2b_res%0d: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                                 nres, overflow, cout, sum, e[W+1], e[W], e[W-1:0]);
                    end
                end
                nres++;
            end
            @(posedge clk);
            #1;
            if (accepted) begin
                if (nacc < N) begin
                    a = xa[nacc]; b = xb[nacc]; sub = xs[nacc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (nres !== N) begin errors++; $display("FAIL b2b_count: got %0d results want %0d", nres, N); end
        checks++; if (nacc !== N) begin errors++; $display("FAIL b2b_accepts: got %0d want %0d", nacc, N); end
        for (int i = 1; i < N && i < nacc; i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] !== EXP_LAT + 2) begin
                errors++;
                $display("FAIL b2b_spacing%0d: got %0d cycles want %0d", i, acc_cyc[i] - acc_cyc[i-1], EXP_LAT + 2);
            end
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid === 1'b1) extra++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra: got %0d trailing out_valid cycles want 0", extra); end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, rs;
        logic s, rc, ro;
        int lat;
        logic [W+1:0] e;
        for (int i = 0; i < 20; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            s = 1'($urandom);
            if (i % 5 == 0) x = {1'b0, {(W-1){1'b1}}};   // steer some toward sign boundary
            if (i % 7 == 0) y = {1'b1, {(W-1){1'b0}}};
            e = model(x, y, s);
            run_op(x, y, s, int'($urandom_range(0, 2)), rs, rc, ro, lat);
            checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL rnd%0d_lat: got %0d want %0d", i, lat, EXP_LAT); end
            checks++; if (rs !== e[W-1:0]) begin errors++; $display("FAIL rnd%0d_sum: a=%h b=%h sub=%b got %h want %h", i, x, y, s, rs, e[W-1:0]); end
            checks++; if (rc !== e[W]) begin errors++; $display("FAIL rnd%0d_cout: got %b want %b", i, rc, e[W]); end
            checks++; if (ro !== e[W+1]) begin errors++; $display("FAIL rnd%0d_ovf: got %b want %b", i, ro, e[W+1]); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
